// File: rtl/bin2bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Feeds the 8-digit seven-segment driver; out-of-range values display as all 'E'.
module bin2bcd_converter #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic                  out_valid
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value representable in DIGITS decimal digits, kept 64 bits wide
  // so the comparison below never truncates either operand.
  localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [IN_W-1:0]    shift_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               ovf_pend_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               overflow_reg;
  logic               out_valid_reg;

  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   scratch_next;
  logic               carry_out;
  logic               in_ovf;
  logic               last_iter;

  // Add 3 to every digit that is 5 or more, all digits in parallel.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                              ? scratch_reg[4*gi +: 4] + 4'd3
                              : scratch_reg[4*gi +: 4];
    end
  endgenerate

  // Bit shifted out of the top digit can only be set for out-of-range input,
  // so it is folded into the overflow flag rather than dropped.
  assign scratch_next = {adj[BCD_W-2:0], shift_reg[IN_W-1]};
  assign carry_out    = adj[BCD_W-1];

  assign in_ovf    = ({{(64-IN_W){1'b0}}, in_data} > MAX_DEC);
  assign last_iter = (count_reg == CNT_W'(IN_W - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      scratch_reg   <= '0;
      count_reg     <= '0;
      ovf_pend_reg  <= 1'b0;
      bcd_reg       <= '0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shift_reg    <= in_data;
            scratch_reg  <= '0;
            count_reg    <= '0;
            ovf_pend_reg <= in_ovf;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          scratch_reg  <= scratch_next;
          shift_reg    <= {shift_reg[IN_W-2:0], 1'b0};
          count_reg    <= count_reg + CNT_W'(1);
          ovf_pend_reg <= ovf_pend_reg | carry_out;
          if (last_iter) begin
            if (ovf_pend_reg | carry_out) begin
              bcd_reg      <= {DIGITS{4'hE}};
              overflow_reg <= 1'b1;
            end else begin
              bcd_reg      <= scratch_next;
              overflow_reg <= 1'b0;
            end
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign bcd       = bcd_reg;
  assign overflow  = overflow_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Directed and table-driven checks of bin2bcd_converter at default widths,
// with a decimal reference model for boundary and random sweeps.
module tb_bin2bcd_converter;

  localparam int IN_W   = 32;
  localparam int DIGITS = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] bcd;
  logic        overflow;
  logic        out_valid;

  int n_cmp = 0;
  int n_err = 0;

  bin2bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bcd(bcd),
    .overflow(overflow),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] din;
    logic [31:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] v, output logic [31:0] b, output logic o);
    logic [31:0] t;
    if (v > 32'd99999999) begin
      b = 32'hEEEEEEEE;
      o = 1'b1;
    end else begin
      t = v;
      b = '0;
      for (int k = 0; k < 8; k++) begin
        b[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
      o = 1'b0;
    end
  endfunction

  // Entered and left at #1 after a rising edge.
  task automatic convert(input logic [31:0] din, input logic [31:0] eb,
                         input logic eo, input string tag);
    int          w;
    int          cyc;
    logic [31:0] prev;
    logic        stable;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, " ready_before"}, 32'(in_ready), 32'd1);
    prev   = bcd;
    stable = 1'b1;
    in_data  = din;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~din;
    check({tag, " busy_after_accept"}, 32'(in_ready), 32'd0);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) break;
      if (bcd !== prev) stable = 1'b0;
    end
    check({tag, " latency"}, 32'(cyc), 32'd32);
    check({tag, " bcd_stable"}, 32'(stable), 32'd1);
    check({tag, " bcd"}, bcd, eb);
    check({tag, " overflow"}, 32'(overflow), 32'(eo));
    @(posedge clk); #1;
    check({tag, " pulse_end"}, 32'(out_valid), 32'd0);
    check({tag, " ready_after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] eb;
    logic        eo;
    logic [31:0] p;
    logic [31:0] v;
    logic [31:0] prev_bcd;
    logic [31:0] pend_bcd;
    logic        pend_ovf;
    logic        stable;
    int          n_acc;
    int          n_res;
    int          last_acc;
    int          seen;

    tbl[0]  = '{32'd0,         32'h00000000, 1'b0};
    tbl[1]  = '{32'd12345678,  32'h12345678, 1'b0};
    tbl[2]  = '{32'd99999999,  32'h99999999, 1'b0};
    tbl[3]  = '{32'd100000000, 32'hEEEEEEEE, 1'b1};
    tbl[4]  = '{32'hFFFFFFFF,  32'hEEEEEEEE, 1'b1};
    tbl[5]  = '{32'd7,         32'h00000007, 1'b0};
    tbl[6]  = '{32'd9,         32'h00000009, 1'b0};
    tbl[7]  = '{32'd10,        32'h00000010, 1'b0};
    tbl[8]  = '{32'd99,        32'h00000099, 1'b0};
    tbl[9]  = '{32'd100,       32'h00000100, 1'b0};
    tbl[10] = '{32'd999999,    32'h00999999, 1'b0};
    tbl[11] = '{32'd1000001,   32'h01000001, 1'b0};
    tbl[12] = '{32'd10000000,  32'h10000000, 1'b0};
    tbl[13] = '{32'd99999998,  32'h99999998, 1'b0};

    // Reset held with in_valid asserted: nothing may be accepted.
    reset    = 1'b0;
    in_valid = 1'b1;
    in_data  = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst bcd", bcd, 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 14; i++)
      convert(tbl[i].din, tbl[i].exp_bcd, tbl[i].exp_ovf, $sformatf("tbl%0d", i));

    // Reset after 10 iterations discards the conversion.
    in_data  = 32'd555;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst bcd", bcd, 32'd0);
    check("midrst overflow", 32'(overflow), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst no_pulse", 32'(seen), 32'd0);
    convert(32'd42, 32'h00000042, 1'b0, "after_midrst");

    // in_valid held high with data changing every cycle.
    n_acc    = 0;
    n_res    = 0;
    last_acc = 0;
    stable   = 1'b1;
    prev_bcd = bcd;
    pend_bcd = '0;
    pend_ovf = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 102; c++) begin
      if (out_valid) begin
        n_res++;
        check($sformatf("hold res%0d bcd", n_res), bcd, pend_bcd);
        check($sformatf("hold res%0d overflow", n_res), 32'(overflow), 32'(pend_ovf));
      end else if (bcd !== prev_bcd) begin
        stable = 1'b0;
      end
      prev_bcd = bcd;
      in_data  = 32'(c * 1237 + 11);
      if (in_ready) begin
        if (n_acc > 0) check("hold accept_interval", 32'(c - last_acc), 32'd34);
        last_acc = c;
        model(in_data, pend_bcd, pend_ovf);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("hold accepts", 32'(n_acc), 32'd3);
    check("hold results", 32'(n_res), 32'd3);
    check("hold bcd_stable", 32'(stable), 32'd1);
    @(posedge clk); #1;

    // Powers of ten and their neighbours.
    p = 32'd10;
    for (int k = 1; k <= 8; k++) begin
      model(p - 32'd1, eb, eo);
      convert(p - 32'd1, eb, eo, $sformatf("p10_%0d_m1", k));
      model(p, eb, eo);
      convert(p, eb, eo, $sformatf("p10_%0d", k));
      model(p + 32'd1, eb, eo);
      convert(p + 32'd1, eb, eo, $sformatf("p10_%0d_p1", k));
      p = p * 32'd10;
    end

    for (int i = 0; i < 1000; i++) begin
      if (i % 4 == 3) v = $urandom;
      else v = $urandom_range(0, 99999999);
      model(v, eb, eo);
      convert(v, eb, eo, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
